// File: rtl/vec_pkg.sv
// Shared types and constants for the vector-store serializer.
package vec_pkg;

  // Control states of the serializer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Byte stride between consecutive elements in memory.
  localparam int ELEM_BYTES = 4;

  // Default element width and the matching element type.
  localparam int ELEM_W = 32;
  typedef logic [ELEM_W-1:0] elem_t;

endpackage

// File: rtl/vector_store_serializer_next_elem.sv
// Combinational priority encoder: returns the lowest set mask bit at or
// above from_i, plus a found flag. Used only when masked stores are built in.
module vstore_next_elem #(
  parameter int V  = 20,
  parameter int IW = $clog2(V + 1)
) (
  input  logic [V-1:0]  mask_i,
  input  logic [IW-1:0] from_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = V - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(from_i))) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_store_serializer.sv
// Vector-store serializer: captures a full V-element vector and streams it
// to memory one element per accepted valid/ready beat, with incrementing
// byte addresses. Optional masked stores are enabled by defining
// VSTORE_MASK_EN (adds mask_i; cleared elements are skipped at no cycle cost).
module vector_store_serializer #(
  parameter int N          = 32,
  parameter int V          = 20,
  parameter int AW         = 32,
  parameter int ELEM_BYTES = vec_pkg::ELEM_BYTES
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start_i,
  input  logic [AW-1:0]       base_addr_i,
  input  logic [V-1:0][N-1:0] vector_i,
`ifdef VSTORE_MASK_EN
  input  logic [V-1:0]        mask_i,
`endif
  output logic                mem_valid_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic [N-1:0]        mem_wdata_o,
  input  logic                mem_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  import vec_pkg::*;

  localparam int IW = $clog2(V + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(V - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       base_q;
  logic [V-1:0][N-1:0] vec_q;
  logic [IW-1:0]       rd_idx;
  logic                capture;
  logic                accept;

  assign capture = (state_q == IDLE) && start_i;
  assign accept  = (state_q == STORE) && mem_ready_i;

`ifdef VSTORE_MASK_EN
  logic [V-1:0]  mask_q;
  logic [V-1:0]  enc_mask;
  logic [IW-1:0] enc_from;
  logic [IW-1:0] enc_idx;
  logic          enc_found;

  // In IDLE look for the first set bit of the incoming mask; in STORE look
  // strictly above the element currently on the bus.
  assign enc_mask = (state_q == IDLE) ? mask_i : mask_q;
  assign enc_from = (state_q == IDLE) ? '0 : idx_q + IW'(1);

  vstore_next_elem #(.V(V), .IW(IW)) u_next_elem (
    .mask_i  (enc_mask),
    .from_i  (enc_from),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );
`endif

  // State and element-index register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Vector, base address (and mask) are latched only when a store is accepted in IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      base_q <= '0;
      vec_q  <= '0;
`ifdef VSTORE_MASK_EN
      mask_q <= '0;
`endif
    end else if (capture) begin
      base_q <= base_addr_i;
      vec_q  <= vector_i;
`ifdef VSTORE_MASK_EN
      mask_q <= mask_i;
`endif
    end
  end

  // Next-state and next-index selection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef VSTORE_MASK_EN
          // An empty mask has nothing to write and goes straight to DONE.
          state_d = enc_found ? STORE : DONE;
          idx_d   = enc_idx;
`else
          state_d = STORE;
          idx_d   = '0;
`endif
        end
      end
      STORE: begin
        if (accept) begin
`ifdef VSTORE_MASK_EN
          state_d = enc_found ? STORE : DONE;
          idx_d   = enc_found ? enc_idx : idx_q + IW'(1);
`else
          state_d = (idx_q == LAST_IDX) ? DONE : STORE;
          idx_d   = idx_q + IW'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Clamp the read index so an end-of-vector index never selects past V-1.
  assign rd_idx = (idx_q < IW'(V)) ? idx_q : '0;

  // Memory-side outputs decoded from the registered state.
  always_comb begin
    mem_valid_o = (state_q == STORE);
    busy_o      = (state_q == STORE) || (state_q == DONE);
    done_o      = (state_q == DONE);
    // Address is base + index*stride; wraps naturally at AW bits.
    mem_addr_o  = base_q + AW'(idx_q) * AW'(ELEM_BYTES);
    mem_wdata_o = (state_q == STORE) ? vec_q[rd_idx] : '0;
  end

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed bench for vector_store_serializer (default V=20, N=32, AW=32).
module tb_vector_store_serializer;

  localparam int N  = 32;
  localparam int V  = 20;
  localparam int AW = 32;

  logic                CLK = 1'b0;
  logic                RST;
  logic                start_i;
  logic [AW-1:0]       base_addr_i;
  logic [V-1:0][N-1:0] vector_i;
`ifdef VSTORE_MASK_EN
  logic [V-1:0]        mask_i;
`endif
  logic                mem_valid_o;
  logic [AW-1:0]       mem_addr_o;
  logic [N-1:0]        mem_wdata_o;
  logic                mem_ready_i;
  logic                busy_o;
  logic                done_o;

  int n_cmp = 0;
  int n_err = 0;

  vector_store_serializer #(.N(N), .V(V), .AW(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .vector_i    (vector_i),
`ifdef VSTORE_MASK_EN
    .mask_i      (mask_i),
`endif
    .mem_valid_o (mem_valid_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic load_ramp;
    for (int i = 0; i < V; i++) vector_i[i] = N'(2 * i);
  endtask

  task automatic test_reset;
    RST = 1'b1; start_i = 1'b0; mem_ready_i = 1'b0;
    base_addr_i = '0; vector_i = '0;
`ifdef VSTORE_MASK_EN
    mask_i = '1;
`endif
    tick; tick;
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got v/b/d=%b want 000", {mem_valid_o, busy_o, done_o});
    end
    n_cmp++;
    if (mem_addr_o !== '0) begin
      n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr_o);
    end
    n_cmp++;
    if (mem_wdata_o !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", mem_wdata_o);
    end
    RST = 1'b0;
    tick;
    n_cmp++;
    if ({mem_valid_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL idle_after_reset: got v/b=%b want 00", {mem_valid_o, busy_o});
    end
  endtask

  task automatic test_basic;
    load_ramp;
    base_addr_i = 32'h100; mem_ready_i = 1'b1; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < V; i++) begin
      n_cmp++;
      if ({mem_valid_o, busy_o, done_o, mem_addr_o, mem_wdata_o} !==
          {3'b110, 32'h100 + 32'(4 * i), 32'(2 * i)}) begin
        n_err++;
        $display("FAIL basic_beat%0d: got v/b/d=%b addr=%h data=%h want 110 addr=%h data=%h",
                 i, {mem_valid_o, busy_o, done_o}, mem_addr_o, mem_wdata_o,
                 32'h100 + 32'(4 * i), 32'(2 * i));
      end
      tick;
    end
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b011) begin
      n_err++; $display("FAIL basic_done: got v/b/d=%b want 011", {mem_valid_o, busy_o, done_o});
    end
    tick;
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++; $display("FAIL basic_idle: got v/b/d=%b want 000", {mem_valid_o, busy_o, done_o});
    end
  endtask

  task automatic test_backpressure;
    int k;
    bit done_seen;
    bit held;
    logic [AW-1:0] prev_addr;
    logic [N-1:0]  prev_data;
    bit acc;
    k = 0; done_seen = 0; held = 0; prev_addr = '0; prev_data = '0;
    load_ramp;
    base_addr_i = 32'h100; mem_ready_i = 1'b0; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (done_o) begin
        done_seen = 1;
      end else begin
        n_cmp++;
        if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h100 + 32'(4 * k) ||
            mem_wdata_o !== 32'(2 * k)) begin
          n_err++;
          $display("FAIL bp_beat%0d: got v=%b addr=%h data=%h want v=1 addr=%h data=%h",
                   k, mem_valid_o, mem_addr_o, mem_wdata_o, 32'h100 + 32'(4 * k), 32'(2 * k));
        end
        if (held) begin
          n_cmp++;
          if (mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) begin
            n_err++;
            $display("FAIL bp_hold: got addr=%h data=%h want addr=%h data=%h",
                     mem_addr_o, mem_wdata_o, prev_addr, prev_data);
          end
        end
        mem_ready_i = cyc[0];
        acc = mem_valid_o && mem_ready_i;
        held = mem_valid_o && !mem_ready_i;
        prev_addr = mem_addr_o; prev_data = mem_wdata_o;
        tick;
        if (acc) k++;
      end
    end
    n_cmp++;
    if (!done_seen || k != V) begin
      n_err++; $display("FAIL bp_count: got accepts=%0d done=%0d want accepts=%0d done=1", k, done_seen, V);
    end
    tick;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++; $display("FAIL bp_done_pulse: got done=%b want 0", done_o);
    end
    mem_ready_i = 1'b1;
  endtask

  task automatic test_start_busy;
    int dones;
    dones = 0;
    load_ramp;
    base_addr_i = 32'h100; mem_ready_i = 1'b1; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < V; i++) begin
      n_cmp++;
      if (mem_valid_o !== 1'b1 || mem_wdata_o !== 32'(2 * i) || mem_addr_o !== 32'h100 + 32'(4 * i)) begin
        n_err++;
        $display("FAIL busy_beat%0d: got v=%b addr=%h data=%h want v=1 addr=%h data=%h",
                 i, mem_valid_o, mem_addr_o, mem_wdata_o, 32'h100 + 32'(4 * i), 32'(2 * i));
      end
      if (i == 5) begin
        start_i = 1'b1; vector_i = '1; base_addr_i = 32'h400;
      end else begin
        start_i = 1'b0;
      end
      tick;
    end
    for (int c = 0; c < 4; c++) begin
      if (done_o) dones++;
      tick;
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++; $display("FAIL busy_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    bit done_seen;
    done_seen = 0;
    load_ramp;
    base_addr_i = 32'h100; mem_ready_i = 1'b1; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    n_cmp++;
    if (mem_addr_o !== 32'h11C || mem_wdata_o !== 32'd14) begin
      n_err++; $display("FAIL rst_pre: got addr=%h data=%h want addr=0000011c data=0000000e", mem_addr_o, mem_wdata_o);
    end
    RST = 1'b1;
    tick;
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b000 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got v/b/d=%b addr=%h data=%h want 000 0 0",
               {mem_valid_o, busy_o, done_o}, mem_addr_o, mem_wdata_o);
    end
    RST = 1'b0;
    tick;
    n_cmp++;
    if ({mem_valid_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL rst_no_beats: got v/b=%b want 00", {mem_valid_o, busy_o});
    end
    base_addr_i = 32'h200; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n_cmp++;
    if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_wdata_o !== 32'd0) begin
      n_err++; $display("FAIL rst_restart: got v=%b addr=%h data=%h want v=1 addr=00000200 data=0",
                        mem_valid_o, mem_addr_o, mem_wdata_o);
    end
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (done_o) done_seen = 1;
      else tick;
    end
    n_cmp++;
    if (!done_seen) begin
      n_err++; $display("FAIL rst_restart_done: got no done within 40 cycles want done");
    end
    tick;
  endtask

  task automatic test_rst_and_start;
    RST = 1'b1; start_i = 1'b1; base_addr_i = 32'h300;
    tick;
    RST = 1'b0; start_i = 1'b0;
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++; $display("FAIL rst_wins: got v/b/d=%b want 000", {mem_valid_o, busy_o, done_o});
    end
    tick;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] ea;
    load_ramp;
    base_addr_i = 32'hFFFF_FFF8; mem_ready_i = 1'b1; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < V; i++) begin
      ea = 32'hFFFF_FFF8 + 32'(4 * i);
      n_cmp++;
      if (mem_valid_o !== 1'b1 || mem_addr_o !== ea || mem_wdata_o !== 32'(2 * i)) begin
        n_err++;
        $display("FAIL wrap_beat%0d: got v=%b addr=%h data=%h want v=1 addr=%h data=%h",
                 i, mem_valid_o, mem_addr_o, mem_wdata_o, ea, 32'(2 * i));
      end
      tick;
    end
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++; $display("FAIL wrap_done: got %b want 1", done_o);
    end
    tick;
  endtask

`ifdef VSTORE_MASK_EN
  task automatic test_mask;
    load_ramp;
    base_addr_i = 32'h100; mem_ready_i = 1'b1;
    mask_i = 20'h00005; start_i = 1'b1;
    tick;
    start_i = 1'b0; mask_i = '1;
    n_cmp++;
    if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_wdata_o !== 32'd0) begin
      n_err++; $display("FAIL mask_beat0: got v=%b addr=%h data=%h want 1 100 0", mem_valid_o, mem_addr_o, mem_wdata_o);
    end
    tick;
    n_cmp++;
    if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h108 || mem_wdata_o !== 32'd4) begin
      n_err++; $display("FAIL mask_beat2: got v=%b addr=%h data=%h want 1 108 4", mem_valid_o, mem_addr_o, mem_wdata_o);
    end
    tick;
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b011) begin
      n_err++; $display("FAIL mask_done: got v/b/d=%b want 011", {mem_valid_o, busy_o, done_o});
    end
    tick;
    mask_i = '0; start_i = 1'b1;
    tick;
    start_i = 1'b0; mask_i = '1;
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b011) begin
      n_err++; $display("FAIL mask_zero: got v/b/d=%b want 011", {mem_valid_o, busy_o, done_o});
    end
    tick;
    n_cmp++;
    if ({mem_valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++; $display("FAIL mask_zero_idle: got v/b/d=%b want 000", {mem_valid_o, busy_o, done_o});
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_start_busy;
    test_reset_mid;
    test_rst_and_start;
    test_wrap;
`ifdef VSTORE_MASK_EN
    test_mask;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
